vga_pixel_unpack: RTL and testbench

//  Downstream stage of the VGA timing/BRAM-address generator. Captures 32-bit frame-buffer words

---
 rtl/vga_pixel_unpack.sv | 180 ++++++++++++++++++
 tb/tb_vga_pixel_unpack.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_unpack.sv
// Unpacks 32-bit frame-buffer words from BRAM into RGB444 pixels with syncs aligned to the data.
// Optional colour-bar generator enabled by `define VGA_PIX_TESTPAT_EN (adds test_pat port).
module vga_pixel_unpack #(
    parameter int RD_LATENCY   = 1,
    parameter int PIX_PER_WORD = 2,
    parameter int BAR_WIDTH    = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_tick,
    input  logic        vid_active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        bram_en,
    input  logic [31:0] bram_dout,
`ifdef VGA_PIX_TESTPAT_EN
    input  logic        test_pat,
`endif
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        underrun,
    output logic        overflow
);

    localparam logic LAST_IDX = 1'(PIX_PER_WORD - 1);

    // Each FIFO entry keeps only the two 12-bit pixels: {word[27:16], word[11:0]}
    logic [23:0]           fifo_q [0:1];
    logic [23:0]           fifo_d [0:1];
    logic [1:0]            count_q, count_d;
    logic                  pix_idx_q, pix_idx_d;
    logic [RD_LATENCY-1:0] en_dly_q, en_dly_d;
    logic                  vsync_in_q;
    logic [11:0]           rgb_q, rgb_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;

    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic [1:0]            wr_idx_s;
    logic [11:0]           fb_pix_s;
    logic                  unused_bits_s;

    assign push_s        = en_dly_q[RD_LATENCY-1];
    assign flush_s       = vsync_in & ~vsync_in_q;
    assign fb_pix_s      = pix_idx_q ? fifo_q[0][23:12] : fifo_q[0][11:0];
    assign unused_bits_s = ^{bram_dout[31:28], bram_dout[15:12]};

`ifdef VGA_PIX_TESTPAT_EN
    localparam logic [15:0] BAR_W16 = 16'(BAR_WIDTH);

    logic [15:0] col_q, col_d;
    logic [2:0]  bar_c_s;
    logic [11:0] bar_rgb_s;

    assign bar_c_s   = 3'd7 - 3'(col_q / BAR_W16);
    assign bar_rgb_s = {{4{bar_c_s[2]}}, {4{bar_c_s[1]}}, {4{bar_c_s[0]}}};
`endif

    // Next-state logic for pixel output, FIFO, strobe delay line and sticky flags
    always_comb begin
        fifo_d[0]  = fifo_q[0];
        fifo_d[1]  = fifo_q[1];
        count_d    = count_q;
        pix_idx_d  = pix_idx_q;
        rgb_d      = rgb_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        pop_s      = 1'b0;
        en_dly_d   = (en_dly_q << 1) | RD_LATENCY'(bram_en);
`ifdef VGA_PIX_TESTPAT_EN
        col_d      = col_q;
`endif

        if (pix_tick) begin
            hsync_d = hsync_in;
            vsync_d = vsync_in;
            if (vid_active_in) begin
                if (count_q != 2'd0) begin
                    rgb_d = fb_pix_s;
                    if (pix_idx_q == LAST_IDX) begin
                        pix_idx_d = 1'b0;
                        pop_s     = 1'b1;
                    end else begin
                        pix_idx_d = pix_idx_q + 1'b1;
                    end
                end else begin
                    rgb_d      = 12'h000;
                    underrun_d = 1'b1;
                end
`ifdef VGA_PIX_TESTPAT_EN
                rgb_d = test_pat ? bar_rgb_s : rgb_d;
                col_d = col_q + 16'd1;
`endif
            end else begin
                rgb_d = 12'h000;
`ifdef VGA_PIX_TESTPAT_EN
                col_d = 16'd0;
`endif
            end
        end else begin
            rgb_d = rgb_q;
        end

        // Frame resync wins over any pop; a word landing in the same clk survives
        wr_idx_s = count_q - {1'b0, pop_s};
        if (flush_s) begin
            pix_idx_d = 1'b0;
            count_d   = push_s ? 2'd1 : 2'd0;
            fifo_d[0] = push_s ? {bram_dout[27:16], bram_dout[11:0]} : fifo_q[0];
        end else begin
            if (pop_s) begin
                fifo_d[0] = fifo_q[1];
            end else begin
                fifo_d[0] = fifo_q[0];
            end
            if (push_s && (count_q == 2'd2)) begin
                overflow_d = 1'b1;
                count_d    = count_q - {1'b0, pop_s};
            end else if (push_s) begin
                fifo_d[wr_idx_s[0]] = {bram_dout[27:16], bram_dout[11:0]};
                count_d             = wr_idx_s + 2'd1;
            end else begin
                count_d = wr_idx_s;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q[0]  <= 24'h000000;
            fifo_q[1]  <= 24'h000000;
            count_q    <= 2'd0;
            pix_idx_q  <= 1'b0;
            en_dly_q   <= '0;
            vsync_in_q <= 1'b0;
            rgb_q      <= 12'h000;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef VGA_PIX_TESTPAT_EN
            col_q      <= 16'd0;
`endif
        end else begin
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            count_q    <= count_d;
            pix_idx_q  <= pix_idx_d;
            en_dly_q   <= en_dly_d;
            vsync_in_q <= vsync_in;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
`ifdef VGA_PIX_TESTPAT_EN
            col_q      <= col_d;
`endif
        end
    end

    assign vga_r    = rgb_q[11:8];
    assign vga_g    = rgb_q[7:4];
    assign vga_b    = rgb_q[3:0];
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Directed self-checking bench for vga_pixel_unpack (default parameters).
module tb_vga_pixel_unpack;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_tick;
    logic        vid_active_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        bram_en;
    logic [31:0] bram_dout;
`ifdef VGA_PIX_TESTPAT_EN
    logic        test_pat;
`endif
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, underrun, overflow;

    int checks = 0;
    int errors = 0;

    vga_pixel_unpack dut (
        .clk           (clk),
        .reset         (reset),
        .pix_tick      (pix_tick),
        .vid_active_in (vid_active_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .bram_en       (bram_en),
        .bram_dout     (bram_dout),
`ifdef VGA_PIX_TESTPAT_EN
        .test_pat      (test_pat),
`endif
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .hsync         (hsync),
        .vsync         (vsync),
        .underrun      (underrun),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        pix_tick      = 1'b0;
        vid_active_in = 1'b0;
        hsync_in      = 1'b0;
        vsync_in      = 1'b0;
        bram_en       = 1'b0;
        bram_dout     = 32'h0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // BRAM read with one clk latency: strobe, then data on the following clk
    task automatic push_word(input logic [31:0] w);
        bram_en = 1'b1;
        step();
        bram_en   = 1'b0;
        bram_dout = w;
        step();
        bram_dout = 32'h0;
    endtask

    task automatic pixel(input logic act, input logic hs, input logic vs);
        pix_tick      = 1'b1;
        vid_active_in = act;
        hsync_in      = hs;
        vsync_in      = vs;
        step();
        pix_tick      = 1'b0;
        vid_active_in = 1'b0;
        hsync_in      = 1'b0;
        vsync_in      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_tick      = 1'($urandom_range(1, 0));
            vid_active_in = 1'($urandom_range(1, 0));
            hsync_in      = 1'($urandom_range(1, 0));
            vsync_in      = 1'($urandom_range(1, 0));
            bram_en       = 1'($urandom_range(1, 0));
            bram_dout     = $urandom;
            step();
        end
        quiet();
        reset = 1'b0;
        step();
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            errors++; $display("FAIL reset_rgb: got %h expected %h", {vga_r, vga_g, vga_b}, 12'h000);
        end
        checks++;
        if ({hsync, vsync, underrun, overflow} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", {hsync, vsync, underrun, overflow}, 4'b0000);
        end
        checks++;
        if (dut.count_q !== 2'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", dut.count_q);
        end
    endtask

    task automatic test_unpack();
        push_word(32'h0ABC_0123);
        checks++;
        if (dut.count_q !== 2'd1) begin
            errors++; $display("FAIL unpack_count1: got %0d expected 1", dut.count_q);
        end
        pixel(1'b1, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h123) begin
            errors++; $display("FAIL unpack_pix0: got %h expected %h", {vga_r, vga_g, vga_b}, 12'h123);
        end
        pixel(1'b1, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'hABC) begin
            errors++; $display("FAIL unpack_pix1: got %h expected %h", {vga_r, vga_g, vga_b}, 12'hABC);
        end
        checks++;
        if (dut.count_q !== 2'd0 || underrun !== 1'b0) begin
            errors++; $display("FAIL unpack_empty: got count %0d underrun %b expected 0 0", dut.count_q, underrun);
        end
    endtask

    task automatic test_blanking();
        push_word(32'h0456_0789);
        pixel(1'b0, 1'b1, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b, hsync} !== {12'h000, 1'b1} || dut.count_q !== 2'd1) begin
            errors++; $display("FAIL blank_hold: got rgb %h hsync %b count %0d expected 000 1 1",
                               {vga_r, vga_g, vga_b}, hsync, dut.count_q);
        end
        pixel(1'b1, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b, hsync} !== {12'h789, 1'b0}) begin
            errors++; $display("FAIL blank_resume: got %h expected %h", {vga_r, vga_g, vga_b, hsync}, {12'h789, 1'b0});
        end
        // vsync rising edge also flushes the half-consumed word
        pixel(1'b0, 1'b0, 1'b1);
        checks++;
        if (vsync !== 1'b1 || dut.count_q !== 2'd0 || dut.pix_idx_q !== 1'b0) begin
            errors++; $display("FAIL blank_vsync: got vsync %b count %0d idx %b expected 1 0 0",
                               vsync, dut.count_q, dut.pix_idx_q);
        end
        step();
    endtask

    task automatic test_underrun();
        pixel(1'b1, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_set: got rgb %h underrun %b expected 000 1", {vga_r, vga_g, vga_b}, underrun);
        end
        push_word(32'h0111_0222);
        pixel(1'b1, 1'b0, 1'b0);
        pixel(1'b0, 1'b0, 1'b0);
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_sticky: got %b expected 1", underrun);
        end
        do_reset();
        checks++;
        if (underrun !== 1'b0 || dut.count_q !== 2'd0) begin
            errors++; $display("FAIL underrun_clear: got underrun %b count %0d expected 0 0", underrun, dut.count_q);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] exp_pix [4];
        exp_pix[0] = 12'h321; exp_pix[1] = 12'hDEF; exp_pix[2] = 12'hABC; exp_pix[3] = 12'h765;
        push_word(32'h0DEF_0321);
        push_word(32'h0765_0ABC);
        push_word(32'h0FFF_0FFF);
        checks++;
        if (dut.count_q !== 2'd2 || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_set: got count %0d overflow %b expected 2 1", dut.count_q, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            pixel(1'b1, 1'b0, 1'b0);
            checks++;
            if ({vga_r, vga_g, vga_b} !== exp_pix[i]) begin
                errors++; $display("FAIL overflow_pix%0d: got %h expected %h", i, {vga_r, vga_g, vga_b}, exp_pix[i]);
            end
        end
        checks++;
        if (dut.count_q !== 2'd0 || overflow !== 1'b1 || underrun !== 1'b0) begin
            errors++; $display("FAIL overflow_end: got count %0d ovf %b und %b expected 0 1 0",
                               dut.count_q, overflow, underrun);
        end
        do_reset();
    endtask

    task automatic test_resync();
        push_word(32'h0DEF_0321);
        push_word(32'h0765_0ABC);
        pixel(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut.count_q !== 2'd2 || dut.pix_idx_q !== 1'b1) begin
            errors++; $display("FAIL resync_pre: got count %0d idx %b expected 2 1", dut.count_q, dut.pix_idx_q);
        end
        vsync_in = 1'b1;
        step();
        checks++;
        if (dut.count_q !== 2'd0 || dut.pix_idx_q !== 1'b0) begin
            errors++; $display("FAIL resync_flush: got count %0d idx %b expected 0 0", dut.count_q, dut.pix_idx_q);
        end
        vsync_in = 1'b0;
        step();
        bram_en = 1'b1;
        step();
        bram_en   = 1'b0;
        bram_dout = 32'h0EEE_0579;
        vsync_in  = 1'b1;
        step();
        bram_dout = 32'h0;
        vsync_in  = 1'b0;
        checks++;
        if (dut.count_q !== 2'd1 || dut.pix_idx_q !== 1'b0) begin
            errors++; $display("FAIL resync_push: got count %0d idx %b expected 1 0", dut.count_q, dut.pix_idx_q);
        end
        pixel(1'b1, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h579) begin
            errors++; $display("FAIL resync_kept: got %h expected %h", {vga_r, vga_g, vga_b}, 12'h579);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_pix [4];
        exp_pix[0] = 12'h111; exp_pix[1] = 12'h222; exp_pix[2] = 12'h333; exp_pix[3] = 12'h444;
        push_word(32'h0222_0111);
        push_word(32'h0444_0333);
        pix_tick      = 1'b1;
        vid_active_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({vga_r, vga_g, vga_b} !== exp_pix[i]) begin
                errors++; $display("FAIL b2b_pix%0d: got %h expected %h", i, {vga_r, vga_g, vga_b}, exp_pix[i]);
            end
        end
        quiet();
        checks++;
        if (dut.count_q !== 2'd0 || underrun !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got count %0d underrun %b expected 0 0", dut.count_q, underrun);
        end
    endtask

    task automatic test_midframe_reset();
        push_word(32'h0AAA_0BBB);
        push_word(32'h0CCC_0DDD);
        do_reset();
        checks++;
        if (dut.count_q !== 2'd0) begin
            errors++; $display("FAIL mreset_count: got %0d expected 0", dut.count_q);
        end
        pixel(1'b1, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || underrun !== 1'b1) begin
            errors++; $display("FAIL mreset_discard: got rgb %h underrun %b expected 000 1", {vga_r, vga_g, vga_b}, underrun);
        end
        do_reset();
    endtask

`ifdef VGA_PIX_TESTPAT_EN
    task automatic test_testpat();
        test_pat = 1'b1;
        pixel(1'b0, 1'b0, 1'b0);
        for (int col = 0; col < 640; col++) begin
            pixel(1'b1, 1'b0, 1'b0);
            if (col == 0 || col == 79) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
                    errors++; $display("FAIL testpat_col%0d: got %h expected FFF", col, {vga_r, vga_g, vga_b});
                end
            end else if (col == 80 || col == 159) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 12'hFF0) begin
                    errors++; $display("FAIL testpat_col%0d: got %h expected FF0", col, {vga_r, vga_g, vga_b});
                end
            end else if (col == 560 || col == 639) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 12'h000) begin
                    errors++; $display("FAIL testpat_col%0d: got %h expected 000", col, {vga_r, vga_g, vga_b});
                end
            end
        end
        test_pat = 1'b0;
        do_reset();
    endtask
`endif

    initial begin
        quiet();
        reset = 1'b1;
`ifdef VGA_PIX_TESTPAT_EN
        test_pat = 1'b0;
`endif
        step();
        test_reset();
        test_unpack();
        test_blanking();
        test_underrun();
        test_overflow();
        test_resync();
        test_back_to_back();
        test_midframe_reset();
`ifdef VGA_PIX_TESTPAT_EN
        test_testpat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
